// File: rtl/edge_pkg.sv
// Shared types and default constants for the multi-channel edge detector.
package edge_pkg;

    typedef enum logic [1:0] {
        EDGE_RISE = 2'b00,
        EDGE_FALL = 2'b01,
        EDGE_BOTH = 2'b10,
        EDGE_OFF  = 2'b11
    } edge_mode_t;

    localparam int DEFAULT_SYNC_STAGES     = 2;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 4;

endpackage

// File: rtl/channel_conditioner.sv
// One channel: synchroniser chain, optional debounce (MULTI_EDGE_DEBOUNCE_EN),
// registered level and combinational rose/fell strobes valid on the flipping edge.
module channel_conditioner
    import edge_pkg::*;
#(
    parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic in,
    output logic level,
    output logic rose,
    output logic fell
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_out;
    logic                   level_q;
    logic                   level_d;
    logic                   flip;

    assign sync_out = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], in};
        end
    end

`ifdef MULTI_EDGE_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Flip only on the DEBOUNCE_CYCLES-th consecutive differing sample.
    assign flip = (sync_out != level_q) && (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1));

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if ((sync_out == level_q) || flip) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign flip = (sync_out != level_q);
`endif

    assign level_d = flip ? sync_out : level_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level_d;
        end
    end

    assign level = level_q;
    assign rose  = flip & sync_out;
    assign fell  = flip & ~sync_out;

endmodule

// File: rtl/multi_edge_detector.sv
// WIDTH-channel edge detector: per-channel conditioners plus mode decode, pulse,
// sticky pending flags and any_pending. Debounce enabled by MULTI_EDGE_DEBOUNCE_EN.
module multi_edge_detector
    import edge_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] clear,
    output logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] pulse,
    output logic [WIDTH-1:0] pending,
    output logic             any_pending
);

    logic [WIDTH-1:0] rose;
    logic [WIDTH-1:0] fell;
    logic [WIDTH-1:0] event_sel;
    logic [WIDTH-1:0] pulse_q;
    logic [WIDTH-1:0] pulse_d;
    logic [WIDTH-1:0] pending_q;
    logic [WIDTH-1:0] pending_d;
    logic             any_q;
    logic             any_d;
    edge_mode_t       mode_e;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chan
            channel_conditioner #(
                .SYNC_STAGES     (SYNC_STAGES),
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_cond (
                .clk   (clk),
                .reset (reset),
                .in    (in[gi]),
                .level (level[gi]),
                .rose  (rose[gi]),
                .fell  (fell[gi])
            );
        end
    endgenerate

    assign mode_e = edge_mode_t'(mode);

    always_comb begin
        event_sel = '0;
        case (mode_e)
            EDGE_RISE: event_sel = rose;
            EDGE_FALL: event_sel = fell;
            EDGE_BOTH: event_sel = rose | fell;
            default:   event_sel = '0;
        endcase
    end

    // Suppress back-to-back pulses so a consumer always sees isolated strobes.
    assign pulse_d   = event_sel & ~pulse_q;
    assign pending_d = pulse_d | (pending_q & ~clear);
    assign any_d     = |pending_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pulse_q   <= '0;
            pending_q <= '0;
            any_q     <= 1'b0;
        end else begin
            pulse_q   <= pulse_d;
            pending_q <= pending_d;
            any_q     <= any_d;
        end
    end

    assign pulse       = pulse_q;
    assign pending     = pending_q;
    assign any_pending = any_q;

endmodule

// File: tb/tb_multi_edge_detector.sv
// Directed + random stimulus against a sample-history reference model of the detector.
module tb_multi_edge_detector;

    localparam int WIDTH = 4;
    localparam int SYNC  = 2;
    localparam int DEB   = 4;
`ifdef MULTI_EDGE_DEBOUNCE_EN
    localparam bit DEB_EN = 1'b1;
`else
    localparam bit DEB_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] in_s;
    logic [1:0]       mode_s;
    logic [WIDTH-1:0] clear_s;
    logic [WIDTH-1:0] level_s;
    logic [WIDTH-1:0] pulse_s;
    logic [WIDTH-1:0] pending_s;
    logic             any_s;

    multi_edge_detector #(
        .WIDTH           (WIDTH),
        .SYNC_STAGES     (SYNC),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in          (in_s),
        .mode        (mode_s),
        .clear       (clear_s),
        .level       (level_s),
        .pulse       (pulse_s),
        .pending     (pending_s),
        .any_pending (any_s)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;
    int cycle  = 0;
    int pc [WIDTH];

    // Reference model state
    logic [WIDTH-1:0] hist [$];
    logic [WIDTH-1:0] m_level, m_pulse, m_pend;
    logic             m_any;
    int               m_run [WIDTH];

    task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cycle, obs, exp);
    endtask

    task automatic model_reset();
        hist.delete();
        m_level = '0; m_pulse = '0; m_pend = '0; m_any = 1'b0;
        for (int i = 0; i < WIDTH; i++) m_run[i] = 0;
    endtask

    // Apply the spec rules for one clock edge using the inputs present at that edge.
    task automatic model_edge();
        logic [WIDTH-1:0] s;
        logic chg, up, ev;
        s = (hist.size() >= SYNC) ? hist[hist.size() - SYNC] : '0;
        hist.push_back(in_s);
        while (hist.size() > SYNC) void'(hist.pop_front());
        for (int i = 0; i < WIDTH; i++) begin
            chg = 1'b0;
            if (s[i] != m_level[i]) begin
                m_run[i]++;
                if (!DEB_EN || m_run[i] == DEB) chg = 1'b1;
            end else begin
                m_run[i] = 0;
            end
            if (chg) begin
                m_run[i]   = 0;
                m_level[i] = s[i];
            end
            up = s[i];
            case (mode_s)
                2'd0:    ev = chg && up;
                2'd1:    ev = chg && !up;
                2'd2:    ev = chg;
                default: ev = 1'b0;
            endcase
            ev = ev && !m_pulse[i];
            m_pend[i]  = ev | (m_pend[i] & ~clear_s[i]);
            m_pulse[i] = ev;
        end
        m_any = |m_pend;
    endtask

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            model_edge();
            @(negedge clk);
            cycle++;
            check("level", level_s, m_level);
            check("pulse", pulse_s, m_pulse);
            check("pending", pending_s, m_pend);
            check("any_pending", {{(WIDTH-1){1'b0}}, any_s}, {{(WIDTH-1){1'b0}}, m_any});
            for (int i = 0; i < WIDTH; i++) pc[i] += int'(pulse_s[i]);
        end
    endtask

    task automatic zero_counts();
        for (int i = 0; i < WIDTH; i++) pc[i] = 0;
    endtask

    task automatic check_count(input string tag, input int ch, input int exp);
        check(tag, WIDTH'(pc[ch]), WIDTH'(exp));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_level"}, level_s, '0);
        check({tag, "_pulse"}, pulse_s, '0);
        check({tag, "_pending"}, pending_s, '0);
        check({tag, "_any"}, {{(WIDTH-1){1'b0}}, any_s}, '0);
    endtask

    initial begin
        reset = 1'b1; in_s = '0; mode_s = 2'd0; clear_s = '0;
        model_reset();
        zero_counts();
        @(negedge clk); @(negedge clk);
        check_all_zero("reset_state");
        reset = 1'b0;

        // Rise mode: single pulse for a held input.
        in_s[0] = 1'b1;
        step(22);
        check_count("rise_single_pulse", 0, 1);

        // Both mode: high 10 cycles then low gives two pulses.
        mode_s = 2'd2; zero_counts();
        in_s[1] = 1'b1; step(10);
        in_s[1] = 1'b0; step(15);
        check_count("both_two_pulses", 1, 2);

        // Off mode: no pulses; then fall mode: one pulse on the falling edge.
        mode_s = 2'd3; zero_counts();
        in_s[2] = 1'b1; step(8);
        in_s[2] = 1'b0; step(8);
        check_count("off_no_pulse", 2, 0);
        in_s[2] = 1'b1; step(8);
        mode_s = 2'd1; zero_counts();
        in_s[2] = 1'b0; step(10);
        check_count("fall_one_pulse", 2, 1);

        // Pending: clear held across a new event, flag must survive that edge.
        mode_s = 2'd0; clear_s = '1; in_s = '0; step(10);
        clear_s = '0; zero_counts();
        clear_s[0] = 1'b1; in_s[0] = 1'b1; step(10);
        clear_s = '0;
        check_count("pending_event_pulse", 0, 1);

        // Short glitch vs. longer pulse (both mode).
        mode_s = 2'd2;
        in_s[1] = 1'b1; step(3);
        in_s[1] = 1'b0; step(10);
        in_s[1] = 1'b1; step(4);
        in_s[1] = 1'b0; step(12);

        // Random traffic.
        for (int r = 0; r < 300; r++) begin
            for (int i = 0; i < WIDTH; i++)
                if ($urandom_range(0, 5) == 0) in_s[i] = ~in_s[i];
            if ($urandom_range(0, 15) == 0) mode_s = 2'($urandom_range(0, 3));
            clear_s = ($urandom_range(0, 3) == 0) ? WIDTH'($urandom) : '0;
            step(1);
        end

        // Reset mid-operation with pending set and debounce in flight.
        clear_s = '0; mode_s = 2'd0; in_s = '0; step(10);
        mode_s = 2'd2; in_s = '1; step(10);
        in_s = '0; step(3);
        reset = 1'b1;
        #1;
        check_all_zero("async_reset");
        model_reset();
        in_s = '1; mode_s = 2'd0;
        @(negedge clk); @(negedge clk);
        check_all_zero("reset_hold");
        reset = 1'b0; zero_counts();
        step(12);
        for (int i = 0; i < WIDTH; i++) check_count("post_reset_rise", i, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/multi_edge_detector.md
# multi_edge_detector

Parametrised, multi-channel edge detector for asynchronous inputs (switches, keys, external strobes). Each channel is synchronised, optionally debounced, and converted to a clean registered level plus a one-cycle event pulse. The edge polarity is selected at run time. A per-channel sticky pending flag lets slow consumers poll events. The block sits between board-level inputs and the control FSMs that consume single-cycle events.

## Interface
- `WIDTH`, 4: number of independent channels (≥1).
- `SYNC_STAGES`, 2: synchroniser flops per channel (≥2).
- `DEBOUNCE_CYCLES`, 4: consecutive differing samples required before level flips (≥1; used only with debounce compiled in).

- `clk` input 1: single clock.
- `reset` input 1: asynchronous, active-high; clears all state immediately.
- `in` input WIDTH: raw asynchronous channel inputs.
- `mode` input 2: edge select, `edge_mode_t`: 00 rise, 01 fall, 10 both, 11 off.
- `clear` input WIDTH: per-channel pending-flag clear, synchronous.
- `level` output WIDTH: conditioned (synchronised/debounced) level.
- `pulse` output WIDTH: one-cycle registered event pulse per channel.
- `pending` output WIDTH: sticky event flags.
- `any_pending` output 1: OR-reduction of `pending`, registered with it.

## Operation
- Per channel: SYNC_STAGES flop chain → `sync_out`. `level` is a register that tracks `sync_out` through the debounce rule.
- Level transition: `level` flips on an edge when the flip condition holds. Without debounce, the condition is `sync_out != level`. With debounce, the condition is that `sync_out != level` on the DEBOUNCE_CYCLES-th consecutive edge.
- `pulse[i]` is registered and asserted for exactly the cycle following a level transition of the enabled polarity:
  - rise: 0→1.
  - fall: 1→0.
  - both: either transition.
  - off: never.
- `pulse` never asserts for 2 consecutive cycles. A held input produces exactly one pulse.
- `mode` is sampled on the same edge as the transition. A mode change mid-stream affects only later transitions; it never generates a pulse by itself.
- `pending[i]` sets on every edge where `pulse[i]` is being set. It clears on an edge with `clear[i]=1` and no new event. A simultaneous set and clear leaves the flag set.
- Reset values: sync chain 0, `level` 0, debounce counters 0, `pulse` 0, `pending` 0, `any_pending` 0. An input held high through reset release produces a rising event after normal latency.

## Timing
- No debounce: input stable before edge 1 gives `sync_out` after edge SYNC_STAGES. `level` and `pulse` update on edge SYNC_STAGES+1.
- Debounce: `level` and `pulse` update on edge SYNC_STAGES+DEBOUNCE_CYCLES. DEBOUNCE_CYCLES=1 is cycle-identical to no debounce.
- `pending` and `any_pending` update on the same edge as `pulse`.
- Reset asserted mid-operation: all outputs drop to 0 asynchronously. In-flight debounce counts are discarded.

## Configuration
- `MULTI_EDGE_DEBOUNCE_EN` defined:
  - Per-channel counter of width $clog2(DEBOUNCE_CYCLES+1).
  - The counter increments while `sync_out != level`.
  - It resets to 0 on any edge where `sync_out == level`, and on a level flip.
  - Glitches shorter than DEBOUNCE_CYCLES cycles at `sync_out` never reach `level`.
- Not defined: no counters; `level <= sync_out` every cycle; DEBOUNCE_CYCLES is ignored.

## Structure
- Package `edge_pkg`:
  - `edge_mode_t` enum (`EDGE_RISE`, `EDGE_FALL`, `EDGE_BOTH`, `EDGE_OFF`).
  - Default constants for SYNC_STAGES and DEBOUNCE_CYCLES.
- Sub-module `channel_conditioner`: one channel's sync chain, optional debounce counter and `level` register. It outputs `level` and a one-cycle `rose`/`fell` strobe pair.
- The top module instantiates WIDTH conditioners via generate and owns `mode` decode, `pulse`, `pending` and `any_pending`.

## Test plan
- Rise mode, no debounce, SYNC_STAGES=2: `in[0]` 0→1 before edge 1 → `level[0]`=1 and `pulse[0]`=1 after edge 3 only, `pending[0]`=1, `any_pending`=1. Holding high for 20 cycles → no further pulses.
- Both mode: `in[1]` high 10 cycles then low → exactly 2 single-cycle pulses, 10 cycles apart.
- Off and fall modes:
  - Off: a rise then fall on `in[2]` → no pulses; `level` still tracks.
  - Switch to fall: the next 1→0 pulses once.
- Pending flag:
  - `clear[0]` asserted on the same edge a new event sets `pending[0]` → flag stays 1.
  - `clear[0]` alone next cycle → flag 0.
  - `any_pending` follows.
- Debounce compiled in with DEBOUNCE_CYCLES=4:
  - 3-cycle high glitch → no level change, no pulse.
  - 4-cycle high → `level`=1 and pulse on edge SYNC_STAGES+4 after the input edge.
- Reset: reset asserted mid-debounce with `pending` set → all outputs 0 immediately. After release with `in` held high, one rising pulse at normal latency.
